score_keeper: RTL and testbench
===============================

Name: score_keeper

Overview:
- Upstream neighbour of the 4-digit score display; produces the binary score `point[9:0]` and the 2-bit digit-scan select `clk_quick[1:0]` that the display consumes.
- Runs a small game-session FSM.
- Counts hit/miss events with a combo bonus and saturating arithmetic.
- Tracks a session high score.

Parameters:
- SCAN_DIV, 18, width of the free-running scan divider; `clk_quick` = top two bits.
- MAX_POINT, 999, saturation ceiling for `point`; must be ≤ 1023.
- MISS_PENALTY, 2, points subtracted per miss, floored at 0.
- COMBO_MAX, 15, combo counter saturation value; must be ≤ 15.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous, active-high reset
- start  input  1  level; rising edge starts a new game
- stop  input  1  level; rising edge ends the current game
- hit  input  1  level, debounced; rising edge = one hit event
- miss  input  1  level, debounced; rising edge = one miss event
- point  output  10  current score, binary, 0..MAX_POINT
- high_score  output  10  best `point` at any game end since reset
- combo  output  4  consecutive-hit count
- playing  output  1  high while in PLAY
- clk_quick  output  2  display digit-scan select

Behaviour:
- Single clock domain: `clk`. Reset is synchronous and active-high on `rst`.
- Reset values:
  - `point` = 0, `high_score` = 0, `combo` = 0.
  - `playing` = 0, state = IDLE.
  - scan counter = 0, so `clk_quick` = 2'b00.
  - All edge-detect history registers = 0. An input held high through reset therefore produces one edge on the first cycle after reset.
- Edge detection:
  - Each of `start`, `stop`, `hit`, `miss` is registered once.
  - An event is `in & ~in_q`.
  - The resulting register update is visible one cycle after the first sampling edge on which the input is high. Latency is 1 clock.
- FSM states: IDLE, PLAY, OVER.
  - IDLE --start--> PLAY. `point` and `combo` clear on the same update.
  - PLAY --stop--> OVER. On this transition, if `point` > `high_score`, then `high_score` ← `point`.
  - OVER --start--> PLAY. `point` and `combo` clear; `high_score` is retained.
  - If `start` and `stop` both occur in PLAY, `stop` wins.
  - A `start` in PLAY is ignored.
- Scoring (PLAY only; hit/miss events in IDLE and OVER are ignored):
  - Hit: `point` ← min(`point` + inc, MAX_POINT), where inc = 1 + (`combo` ≥ 4) + (`combo` ≥ 8). Then `combo` ← min(`combo` + 1, COMBO_MAX). inc uses the pre-update `combo`.
  - Miss: `point` ← (`point` ≥ MISS_PENALTY) ? `point` − MISS_PENALTY : 0. Then `combo` ← 0.
  - Hit and miss in the same cycle: miss wins; the hit is discarded.
  - `stop` and hit in the same cycle: the hit is discarded. The score frozen into OVER is the pre-event value.
- Arithmetic:
  - Compute the sum at 11 bits before comparing against MAX_POINT. No wrap is permitted.
  - `point` holds its value in OVER until the next `start`.
- Scan counter:
  - Free-running SCAN_DIV-bit up-counter, wraps naturally, independent of the FSM.
  - `clk_quick` = cnt[SCAN_DIV-1:SCAN_DIV-2]. Sequence 00→01→10→11→00, each held 2^(SCAN_DIV-2) cycles.
- `playing` is registered, i.e. equal to (state == PLAY).

Optional Feature:
- Macro: HIGH_SCORE_EN.
- Defined: `high_score` register and update logic as above.
- Undefined:
  - `high_score` is tied to 10'd0 with no flops.
  - `point` still holds its value in OVER.
  - All other behaviour is unchanged.

Decomposition:
- Package `score_pkg`:
  - state enum (IDLE=2'd0, PLAY=2'd1, OVER=2'd2);
  - POINT_W=10, COMBO_W=4;
  - combo bonus thresholds 4 and 8.
- Sub-module `rise_edge`:
  - one flop plus AND;
  - synchronous active-high reset to 0;
  - instantiated four times for `start`, `stop`, `hit`, `miss`.

Test Plan:
- Reset: assert `rst` 3 cycles with `hit` high → all outputs 0 after reset; the first post-reset cycle sees one hit edge, which is ignored because state is IDLE; `point` stays 0.
- Combo scoring: `start`, then 10 hit pulses → `point` sequence 1,2,3,4,6,8,10,12,15,18; `combo` = 10.
- Miss handling:
  - At `point` = 18, miss → `point` = 16, `combo` = 0.
  - Then from `point` = 1, miss → `point` = 0 (floored).
- Saturation: force play to `point` = 998 with `combo` ≥ 8, then hit → `point` = 999; further hits keep 999; `combo` stops at 15.
- Simultaneous and game-end events:
  - hit+miss in the same cycle → miss applied only.
  - `stop` with `point` = 37 and `high_score` = 20 → OVER, `high_score` = 37.
  - Next game ends at 12 → `high_score` stays 37.
  - Without HIGH_SCORE_EN → `high_score` always 0.
- Scan: SCAN_DIV=4 → `clk_quick` steps 00,01,10,11 every 4 cycles, wraps at cycle 16, unaffected by `start`/`stop`.

Source files
------------

// File: rtl/score_pkg.sv
// ============================================================================
//  Module      : score_pkg
//  Description : Shared types and constants for the score_keeper block.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package score_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PLAY = 2'd1,
        OVER = 2'd2
    } state_t;

    localparam int POINT_W = 10;
    localparam int COMBO_W = 4;

    localparam logic [COMBO_W-1:0] COMBO_T1 = 4'd4;
    localparam logic [COMBO_W-1:0] COMBO_T2 = 4'd8;

    // Bonus on top of the base single point, taken from the pre-hit combo.
    function automatic logic [1:0] combo_bonus(input logic [COMBO_W-1:0] i_combo);
        logic [1:0] v;
        v = 2'd0;
        if (i_combo >= COMBO_T1) v = v + 2'd1;
        if (i_combo >= COMBO_T2) v = v + 2'd1;
        return v;
    endfunction

endpackage

`default_nettype wire

// File: rtl/score_keeper_rise_edge.sv
// ============================================================================
//  Module      : rise_edge
//  Description : Single-flop rising-edge detector (pulse = in & ~in_q).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rise_edge (
    input  logic clk,
    input  logic rst,
    input  logic i_d,
    output logic o_pulse
);

    logic r_q;

    always_ff @(posedge clk) begin
        if (rst) r_q <= 1'b0;
        else     r_q <= i_d;
    end

    assign o_pulse = i_d & ~r_q;

endmodule

`default_nettype wire

// File: rtl/score_keeper.sv
// ============================================================================
//  Module      : score_keeper
//  Description : Game-session FSM, combo scoring, high score and digit-scan
//                select. Optional macro HIGH_SCORE_EN enables high_score.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module score_keeper
    import score_pkg::*;
#(
    parameter int SCAN_DIV     = 18,
    parameter int MAX_POINT    = 999,
    parameter int MISS_PENALTY = 2,
    parameter int COMBO_MAX    = 15
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               stop,
    input  logic               hit,
    input  logic               miss,
    output logic [POINT_W-1:0] point,
    output logic [POINT_W-1:0] high_score,
    output logic [COMBO_W-1:0] combo,
    output logic               playing,
    output logic [1:0]         clk_quick
);

    localparam logic [POINT_W:0]    c_max_sum = (POINT_W+1)'(MAX_POINT);
    localparam logic [POINT_W-1:0]  c_max_pt  = POINT_W'(MAX_POINT);
    localparam logic [POINT_W-1:0]  c_penalty = POINT_W'(MISS_PENALTY);
    localparam logic [COMBO_W-1:0]  c_cmb_max = COMBO_W'(COMBO_MAX);
    localparam logic [SCAN_DIV-1:0] c_scan_one = SCAN_DIV'(1);

    logic w_start_ev, w_stop_ev, w_hit_ev, w_miss_ev;

    rise_edge u_edge_start (.clk(clk), .rst(rst), .i_d(start), .o_pulse(w_start_ev));
    rise_edge u_edge_stop  (.clk(clk), .rst(rst), .i_d(stop),  .o_pulse(w_stop_ev));
    rise_edge u_edge_hit   (.clk(clk), .rst(rst), .i_d(hit),   .o_pulse(w_hit_ev));
    rise_edge u_edge_miss  (.clk(clk), .rst(rst), .i_d(miss),  .o_pulse(w_miss_ev));

    state_t r_state, w_state_nxt;
    logic   w_clear, w_end, w_do_hit, w_do_miss;

    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_start_ev) w_state_nxt = PLAY;
            PLAY:    if (w_stop_ev)  w_state_nxt = OVER;
            OVER:    if (w_start_ev) w_state_nxt = PLAY;
            default: w_state_nxt = IDLE;
        endcase
    end

    // stop beats scoring events, miss beats hit.
    always_comb begin
        w_clear   = 1'b0;
        w_end     = 1'b0;
        w_do_hit  = 1'b0;
        w_do_miss = 1'b0;
        case (r_state)
            IDLE, OVER: w_clear = w_start_ev;
            PLAY: begin
                w_end     = w_stop_ev;
                w_do_miss = ~w_stop_ev & w_miss_ev;
                w_do_hit  = ~w_stop_ev & ~w_miss_ev & w_hit_ev;
            end
            default: ;
        endcase
    end

    logic [POINT_W-1:0] r_point;
    logic [COMBO_W-1:0] r_combo;
    logic [1:0]         w_inc;
    logic [POINT_W:0]   w_sum;
    logic [POINT_W-1:0] w_hit_pt, w_miss_pt;
    logic [COMBO_W-1:0] w_combo_inc;

    assign w_inc       = 2'd1 + combo_bonus(r_combo);
    assign w_sum       = {1'b0, r_point} + {{(POINT_W-1){1'b0}}, w_inc};
    assign w_hit_pt    = (w_sum > c_max_sum) ? c_max_pt : w_sum[POINT_W-1:0];
    assign w_miss_pt   = (r_point >= c_penalty) ? (r_point - c_penalty) : '0;
    assign w_combo_inc = (r_combo >= c_cmb_max) ? r_combo : (r_combo + 4'd1);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_point <= '0;
            r_combo <= '0;
        end else if (w_clear) begin
            r_point <= '0;
            r_combo <= '0;
        end else if (w_do_miss) begin
            r_point <= w_miss_pt;
            r_combo <= '0;
        end else if (w_do_hit) begin
            r_point <= w_hit_pt;
            r_combo <= w_combo_inc;
        end
    end

    logic r_playing;

    always_ff @(posedge clk) begin
        if (rst) r_playing <= 1'b0;
        else     r_playing <= (w_state_nxt == PLAY);
    end

`ifdef HIGH_SCORE_EN
    logic [POINT_W-1:0] r_high_score;

    always_ff @(posedge clk) begin
        if (rst)
            r_high_score <= '0;
        else if (w_end && (r_point > r_high_score))
            r_high_score <= r_point;
    end

    assign high_score = r_high_score;
`else
    assign high_score = '0;
`endif

    logic [SCAN_DIV-1:0] r_scan;

    always_ff @(posedge clk) begin
        if (rst) r_scan <= '0;
        else     r_scan <= r_scan + c_scan_one;
    end

    assign clk_quick = r_scan[SCAN_DIV-1:SCAN_DIV-2];
    assign point     = r_point;
    assign combo     = r_combo;
    assign playing   = r_playing;

endmodule

`default_nettype wire

// File: tb/tb_score_keeper.sv
// ============================================================================
//  Module      : tb_score_keeper
//  Description : Self-checking bench for score_keeper (SCAN_DIV = 4).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_score_keeper;

    localparam int HS_ON =
`ifdef HIGH_SCORE_EN
        1;
`else
        0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0, stop = 1'b0, hit = 1'b0, miss = 1'b0;
    logic [9:0] point, high_score;
    logic [3:0] combo;
    logic       playing;
    logic [1:0] clk_quick;

    score_keeper #(
        .SCAN_DIV(4), .MAX_POINT(999), .MISS_PENALTY(2), .COMBO_MAX(15)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .hit(hit), .miss(miss),
        .point(point), .high_score(high_score), .combo(combo),
        .playing(playing), .clk_quick(clk_quick)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [9:0] pt;
        logic [3:0] cb;
        logic       pl;
        logic [9:0] hs;
        logic [1:0] cq;
    } exp_t;

    typedef struct {
        logic r, s, p, h, m;
        int   pt, cb, pl;
    } vec_t;

    exp_t sb[$];
    vec_t tab[$];
    int   n_chk = 0, n_pass = 0, cyc = 0;

    // Behavioural reference model
    int   m_pt = 0, m_cb = 0, m_hs = 0, m_cnt = 0, m_st = 0;
    logic ps = 0, pp = 0, ph = 0, pm = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s @cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
    endtask

    task automatic model(input logic r, s, p, h, m);
        logic es, et, eh, em;
        int   inc;
        if (r) begin
            m_pt = 0; m_cb = 0; m_hs = 0; m_cnt = 0; m_st = 0;
            ps = 0; pp = 0; ph = 0; pm = 0;
            return;
        end
        es = s & ~ps; et = p & ~pp; eh = h & ~ph; em = m & ~pm;
        m_cnt = (m_cnt + 1) % 16;
        case (m_st)
            1: begin
                if (et) begin
                    m_st = 2;
                    if (HS_ON != 0 && m_pt > m_hs) m_hs = m_pt;
                end else if (em) begin
                    m_pt = (m_pt >= 2) ? m_pt - 2 : 0;
                    m_cb = 0;
                end else if (eh) begin
                    inc  = 1 + ((m_cb >= 4) ? 1 : 0) + ((m_cb >= 8) ? 1 : 0);
                    m_pt = (m_pt + inc > 999) ? 999 : m_pt + inc;
                    m_cb = (m_cb >= 15) ? 15 : m_cb + 1;
                end
            end
            default: if (es) begin m_st = 1; m_pt = 0; m_cb = 0; end
        endcase
        ps = s; pp = p; ph = h; pm = m;
    endtask

    task automatic step(input logic r, s, p, h, m,
                        input bit use_tab, input int tpt, input int tcb, input int tpl);
        exp_t e, g;
        @(negedge clk);
        rst = r; start = s; stop = p; hit = h; miss = m;
        model(r, s, p, h, m);
        e.pt = 10'(m_pt); e.cb = 4'(m_cb); e.pl = (m_st == 1);
        e.hs = 10'(m_hs); e.cq = 2'(m_cnt >> 2);
        if (use_tab) begin
            e.pt = 10'(tpt); e.cb = 4'(tcb); e.pl = (tpl != 0);
        end
        sb.push_back(e);
        @(posedge clk);
        #1;
        cyc++;
        g = sb.pop_front();
        chk("point",      point,      g.pt);
        chk("combo",      combo,      g.cb);
        chk("playing",    playing,    g.pl);
        chk("high_score", high_score, g.hs);
        chk("clk_quick",  clk_quick,  g.cq);
    endtask

    task automatic cy(input logic s, p, h, m);
        step(1'b0, s, p, h, m, 1'b0, 0, 0, 0);
    endtask

    task automatic hitp();
        cy(0, 0, 1, 0); cy(0, 0, 0, 0);
    endtask

    task automatic missp();
        cy(0, 0, 0, 1); cy(0, 0, 0, 0);
    endtask

    task automatic startp();
        cy(1, 0, 0, 0); cy(0, 0, 0, 0);
    endtask

    task automatic stopp();
        cy(0, 1, 0, 0); cy(0, 0, 0, 0);
    endtask

    task automatic add(input logic r, s, p, h, m, input int pt, cb, pl);
        vec_t v;
        v.r = r; v.s = s; v.p = p; v.h = h; v.m = m;
        v.pt = pt; v.cb = cb; v.pl = pl;
        tab.push_back(v);
    endtask

    initial begin
        int seq[10];
        seq = '{1, 2, 3, 4, 6, 8, 10, 12, 15, 18};

        // Reset with hit held high, then start and ten hit pulses
        repeat (3) add(1, 0, 0, 1, 0, 0, 0, 0);
        add(0, 0, 0, 1, 0, 0, 0, 0);
        add(0, 0, 0, 0, 0, 0, 0, 0);
        add(0, 1, 0, 0, 0, 0, 0, 1);
        add(0, 0, 0, 0, 0, 0, 0, 1);
        for (int i = 0; i < 10; i++) begin
            add(0, 0, 0, 1, 0, seq[i], i + 1, 1);
            add(0, 0, 0, 0, 0, seq[i], i + 1, 1);
        end
        foreach (tab[i])
            step(tab[i].r, tab[i].s, tab[i].p, tab[i].h, tab[i].m,
                 1'b1, tab[i].pt, tab[i].cb, tab[i].pl);
        chk("combo_10", combo, 10);

        // Miss at 18, then hit+miss together
        missp();
        chk("miss_18_pt", point, 16);
        chk("miss_18_combo", combo, 0);
        cy(0, 0, 1, 1); cy(0, 0, 0, 0);
        chk("hit_miss_pt", point, 14);
        repeat (5) hitp();
        chk("pre_stop_20", point, 20);

        // start in PLAY is ignored; stop+hit freezes the pre-event score
        startp();
        chk("start_in_play", point, 20);
        cy(0, 1, 1, 0); cy(0, 0, 0, 0);
        chk("stop_hit_pt", point, 20);
        chk("stop_playing", playing, 0);
        chk("hs_20", high_score, (HS_ON != 0) ? 20 : 0);
        hitp();
        chk("hit_in_over", point, 20);

        // Game ending at 37 via simultaneous start+stop (stop wins)
        startp();
        chk("restart_clear", point, 0);
        repeat (16) hitp();
        missp();
        repeat (3) hitp();
        chk("pt_37", point, 37);
        cy(1, 1, 0, 0); cy(0, 0, 0, 0);
        chk("start_stop_playing", playing, 0);
        chk("hs_37", high_score, (HS_ON != 0) ? 37 : 0);

        // Floor at zero, then a lower game end keeps the high score
        startp();
        hitp();
        missp();
        chk("miss_floor", point, 0);
        repeat (8) hitp();
        chk("pt_12", point, 12);
        stopp();
        chk("hs_kept_37", high_score, (HS_ON != 0) ? 37 : 0);

        // Saturation at MAX_POINT
        startp();
        repeat (8) hitp();
        missp();
        repeat (8) hitp();
        missp();
        repeat (8) hitp();
        chk("pt_32", point, 32);
        repeat (322) hitp();
        chk("sat_998", point, 998);
        chk("combo_cap", combo, 15);
        hitp();
        chk("sat_999", point, 999);
        repeat (3) hitp();
        chk("sat_hold", point, 999);
        chk("combo_hold", combo, 15);
        stopp();
        chk("hs_999", high_score, (HS_ON != 0) ? 999 : 0);
        repeat (20) cy(0, 0, 0, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got cycle %0d, expected completion", cyc);
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
